operand_skid_stage: RTL and testbench

OPERAND_SKID_STAGE -- requirements
Module: operand_skid_stage

---
 rtl/operand_skid_stage.sv | 148 ++++++++++++++
 tb/tb_operand_skid_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/operand_skid_stage.sv
// Operand register stage for an adder: captures A, B and Cin with add/sub transform, 2-entry skid buffer.
// Latency: 1 cycle from input transfer to out_valid when empty; one set per cycle with out_ready held high.
// Backpressure: in_ready is registered and drops only when both output and skid registers are occupied.
module operand_skid_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] A_D,
   input  logic [DATA_WIDTH-1:0] B_D,
   input  logic                  Cin_D,
   input  logic                  sub_D,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] A_Q,
   output logic [DATA_WIDTH-1:0] B_Q,
   output logic                  Cin_Q,
   output logic [CNT_WIDTH-1:0]  accept_cnt
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_HALF  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_in_ready;

   logic [DATA_WIDTH-1:0] r_a_out;
   logic [DATA_WIDTH-1:0] r_b_out;
   logic                  r_cin_out;
   logic [DATA_WIDTH-1:0] r_a_skid;
   logic [DATA_WIDTH-1:0] r_b_skid;
   logic                  r_cin_skid;
   logic [CNT_WIDTH-1:0]  r_cnt;

   logic                  w_in_xfer;
   logic                  w_out_xfer;
   logic [DATA_WIDTH-1:0] w_b_xf;
   logic                  w_cin_xf;
   logic                  w_ld_out_in;
   logic                  w_ld_out_skid;
   logic                  w_ld_skid;

   // in_ready is forced low while rst is high so nothing is accepted in the reset cycle
   assign in_ready   = r_in_ready & ~rst;
   assign out_valid  = (r_state != ST_EMPTY);
   assign w_in_xfer  = in_valid & in_ready;
   assign w_out_xfer = out_valid & out_ready;

   // Subtract is presented to the adder as A + ~B + 1, so the transform happens at capture
   assign w_b_xf   = sub_D ? ~B_D : B_D;
   assign w_cin_xf = sub_D ? 1'b1 : Cin_D;

   assign A_Q        = r_a_out;
   assign B_Q        = r_b_out;
   assign Cin_Q      = r_cin_out;
   assign accept_cnt = r_cnt;

   // Next-state and register-load selection from occupancy and the two handshakes
   always_comb begin
      w_state_nxt   = r_state;
      w_ld_out_in   = 1'b0;
      w_ld_out_skid = 1'b0;
      w_ld_skid     = 1'b0;
      unique case (r_state)
         ST_EMPTY: begin
            if (w_in_xfer) begin
               w_state_nxt = ST_HALF;
               w_ld_out_in = 1'b1;
            end
         end
         ST_HALF: begin
            if (w_in_xfer && w_out_xfer) begin
               w_ld_out_in = 1'b1;
            end else if (w_in_xfer) begin
               w_state_nxt = ST_FULL;
               w_ld_skid   = 1'b1;
            end else if (w_out_xfer) begin
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            // in_ready is low here, so only the drain path exists
            if (w_out_xfer) begin
               w_state_nxt   = ST_HALF;
               w_ld_out_skid = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_EMPTY;
         end
      endcase
   end

   // Occupancy state and the registered ready derived from the next occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_EMPTY;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= (w_state_nxt != ST_FULL);
      end
   end

   // Output and skid operand registers; output holds unless a load is selected
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a_out    <= '0;
         r_b_out    <= '0;
         r_cin_out  <= 1'b0;
         r_a_skid   <= '0;
         r_b_skid   <= '0;
         r_cin_skid <= 1'b0;
      end else begin
         if (w_ld_out_in) begin
            r_a_out   <= A_D;
            r_b_out   <= w_b_xf;
            r_cin_out <= w_cin_xf;
         end else if (w_ld_out_skid) begin
            r_a_out   <= r_a_skid;
            r_b_out   <= r_b_skid;
            r_cin_out <= r_cin_skid;
         end
         if (w_ld_skid) begin
            r_a_skid   <= A_D;
            r_b_skid   <= w_b_xf;
            r_cin_skid <= w_cin_xf;
         end
      end
   end

   // Accepted-transfer counter, wraps naturally at its width
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_in_xfer) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_operand_skid_stage.sv
// Scoreboard bench for operand_skid_stage: directed vectors push expected sets, a monitor pops on output transfers.
// A second instance with a 4-bit counter shares the stimulus to exercise counter wrap.
// Inputs driven 1 time unit after the rising edge; outputs sampled on the falling edge.
module tb_operand_skid_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] A_D;
   logic [31:0] B_D;
   logic        Cin_D;
   logic        sub_D;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] A_Q;
   logic [31:0] B_Q;
   logic        Cin_Q;
   logic [15:0] accept_cnt;

   logic        in_ready4;
   logic        out_valid4;
   logic [31:0] A_Q4;
   logic [31:0] B_Q4;
   logic        Cin_Q4;
   logic [3:0]  accept_cnt4;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
   } exp_t;

   exp_t q[$];
   exp_t held;
   logic held_vld = 1'b0;
   int   n_tests  = 0;
   int   n_fail   = 0;
   int   n_out    = 0;

   always #5 clk = ~clk;

   operand_skid_stage #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .A_D(A_D), .B_D(B_D), .Cin_D(Cin_D), .sub_D(sub_D),
      .out_valid(out_valid), .out_ready(out_ready),
      .A_Q(A_Q), .B_Q(B_Q), .Cin_Q(Cin_Q), .accept_cnt(accept_cnt)
   );

   operand_skid_stage #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
      .A_D(A_D), .B_D(B_D), .Cin_D(Cin_D), .sub_D(sub_D),
      .out_valid(out_valid4), .out_ready(out_ready),
      .A_Q(A_Q4), .B_Q(B_Q4), .Cin_Q(Cin_Q4), .accept_cnt(accept_cnt4)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: hold-stability while stalled, and in-order scoreboard on each output transfer
   always @(negedge clk) begin
      if (held_vld) begin
         chk("hold_A", {32'd0, A_Q}, {32'd0, held.a});
         chk("hold_B", {32'd0, B_Q}, {32'd0, held.b});
         chk("hold_Cin", {63'd0, Cin_Q}, {63'd0, held.cin});
      end
      held_vld = out_valid && !out_ready && !rst;
      held     = '{a: A_Q, b: B_Q, cin: Cin_Q};
      if (out_valid && out_ready && !rst) begin
         if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_output: got A=0x%0h B=0x%0h with no set expected", A_Q, B_Q);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("out_A", {32'd0, A_Q}, {32'd0, e.a});
            chk("out_B", {32'd0, B_Q}, {32'd0, e.b});
            chk("out_Cin", {63'd0, Cin_Q}, {63'd0, e.cin});
            n_out++;
         end
      end
   end

   // Offer one set until accepted (bounded); expected transformed values supplied by caller
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub,
                       input logic [31:0] eb, input logic ecin, output int waited);
      waited   = 0;
      in_valid = 1'b1;
      A_D      = a;
      B_D      = b;
      Cin_D    = cin;
      sub_D    = sub;
      while (1) begin
         @(negedge clk);
         if (in_ready) break;
         waited++;
         if (waited > 20) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 20 cycles");
            in_valid = 1'b0;
            return;
         end
      end
      @(posedge clk);
      q.push_back('{a: a, b: eb, cin: ecin});
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int w;
      int wsum;
      int out0;
      logic [31:0] sa, sb;
      logic        scin, ssub;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      A_D = '0; B_D = '0; Cin_D = 1'b0; sub_D = 1'b0;

      // Reset state
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      @(posedge clk); #1;
      chk("rst_A_Q", {32'd0, A_Q}, 64'd0);
      chk("rst_B_Q", {32'd0, B_Q}, 64'd0);
      chk("rst_Cin_Q", {63'd0, Cin_Q}, 64'd0);
      chk("rst_cnt", {48'd0, accept_cnt}, 64'd0);
      rst = 1'b0; #1;
      chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

      // Add pass then sub pass, out_ready high
      out_ready = 1'b1;
      send(32'h5, 32'h3, 1'b1, 1'b0, 32'h3, 1'b1, w);
      chk("add_out_valid", {63'd0, out_valid}, 64'd1);
      chk("add_A_Q", {32'd0, A_Q}, 64'h5);
      chk("add_B_Q", {32'd0, B_Q}, 64'h3);
      chk("add_Cin_Q", {63'd0, Cin_Q}, 64'd1);
      chk("add_cnt", {48'd0, accept_cnt}, 64'd1);
      send(32'h10, 32'h1, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, w);
      chk("sub_A_Q", {32'd0, A_Q}, 64'h10);
      chk("sub_B_Q", {32'd0, B_Q}, 64'hFFFF_FFFE);
      chk("sub_Cin_Q", {63'd0, Cin_Q}, 64'd1);
      chk("sub_cnt", {48'd0, accept_cnt}, 64'd2);
      idle(3);
      chk("drain1_q_empty", q.size(), 64'd0);

      // Backpressure: two sets fill the stage, third stalls
      out_ready = 1'b0;
      send(32'h11, 32'h22, 1'b0, 1'b0, 32'h22, 1'b0, w);
      send(32'h33, 32'h0F, 1'b1, 1'b1, 32'hFFFF_FFF0, 1'b1, w);
      chk("bp_full_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      in_valid = 1'b1; A_D = 32'h55; B_D = 32'h66; Cin_D = 1'b1; sub_D = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         chk("bp_stall_in_ready", {63'd0, in_ready}, 64'd0);
         chk("bp_stall_A_Q", {32'd0, A_Q}, 64'h11);
         chk("bp_stall_cnt", {48'd0, accept_cnt}, 64'd4);
      end
      out_ready = 1'b1;
      send(32'h55, 32'h66, 1'b1, 1'b0, 32'h66, 1'b1, w);
      idle(3);
      chk("bp_cnt", {48'd0, accept_cnt}, 64'd5);
      chk("bp_n_out", n_out, 64'd5);
      chk("bp_q_empty", q.size(), 64'd0);

      // Streaming 100 sets after a fresh reset
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
      out_ready = 1'b1;
      out0 = n_out;
      wsum = 0;
      for (int i = 0; i < 100; i++) begin
         sa   = 32'h1000 + i;
         sb   = i * 7;
         scin = i[1];
         ssub = i[0];
         send(sa, sb, scin, ssub, ssub ? ~sb : sb, ssub ? 1'b1 : scin, w);
         wsum += w;
      end
      idle(2);
      chk("stream_stall_cycles", wsum, 64'd0);
      chk("stream_n_out", n_out - out0, 64'd100);
      chk("stream_cnt", {48'd0, accept_cnt}, 64'd100);
      chk("stream_q_empty", q.size(), 64'd0);

      // Reset while FULL discards both held sets
      out_ready = 1'b0;
      send(32'hA1, 32'hA2, 1'b0, 1'b0, 32'hA2, 1'b0, w);
      send(32'hB1, 32'hB2, 1'b0, 1'b0, 32'hB2, 1'b0, w);
      chk("full_in_ready", {63'd0, in_ready}, 64'd0);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("rstfull_in_ready_during", {63'd0, in_ready}, 64'd0);
      @(posedge clk);
      q.delete();
      #1;
      rst = 1'b0; #1;
      chk("rstfull_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rstfull_A_Q", {32'd0, A_Q}, 64'd0);
      chk("rstfull_B_Q", {32'd0, B_Q}, 64'd0);
      chk("rstfull_Cin_Q", {63'd0, Cin_Q}, 64'd0);
      chk("rstfull_cnt", {48'd0, accept_cnt}, 64'd0);
      chk("rstfull_in_ready_after", {63'd0, in_ready}, 64'd1);

      // 17 transfers: 16-bit counter reads 17, 4-bit counter wraps to 1
      out_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         send(32'h2000 + i, 32'h40 + i, 1'b0, 1'b0, 32'h40 + i, 1'b0, w);
      end
      idle(2);
      chk("wrap_cnt16", {48'd0, accept_cnt}, 64'd17);
      chk("wrap_cnt4", {60'd0, accept_cnt4}, 64'd1);
      chk("wrap_q_empty", q.size(), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
